// File: rtl/mul_pkg.sv
// Shared types and widths for the multiply issue/writeback controller.
//   MUL_W  : operand / result word width
//   PROD_W : full product width
//   RA_W   : register address width
//   mul_state_e : controller states
package mul_pkg;

  localparam int unsigned MUL_W  = 32;
  localparam int unsigned PROD_W = 64;
  localparam int unsigned RA_W   = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    WB    = 2'd3
  } mul_state_e;

endpackage

// File: rtl/mul_sign_fix.sv
// Combinational sign handling around the unsigned multiplier core.
//   i_signed      : operands are two's complement
//   i_a, i_b      : raw operands (MSB is the sign bit)
//   o_abs_a/b     : magnitudes handed to the unsigned core
//   o_neg         : product must be negated
//   i_neg, i_prod : captured negate flag and unsigned product
//   o_prod        : sign-corrected product, modulo 2^PROD_W
module mul_sign_fix
  import mul_pkg::*;
(
  input  logic              i_signed,
  input  logic [MUL_W-1:0]  i_a,
  input  logic [MUL_W-1:0]  i_b,
  output logic [MUL_W-1:0]  o_abs_a,
  output logic [MUL_W-1:0]  o_abs_b,
  output logic              o_neg,
  input  logic              i_neg,
  input  logic [PROD_W-1:0] i_prod,
  output logic [PROD_W-1:0] o_prod
);

  // 0x80000000 negates to itself, which is the correct unsigned magnitude.
  assign o_abs_a = (i_signed && i_a[MUL_W-1]) ? (~i_a + MUL_W'(1)) : i_a;
  assign o_abs_b = (i_signed && i_b[MUL_W-1]) ? (~i_b + MUL_W'(1)) : i_b;
  assign o_neg   = i_signed & (i_a[MUL_W-1] ^ i_b[MUL_W-1]);
  assign o_prod  = i_neg ? (~i_prod + PROD_W'(1)) : i_prod;

endmodule

// File: rtl/mul_ctrl.sv
// Multiply issue/writeback controller between EX and the multi-cycle multiplier.
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   ex_mul/ex_signed/ex_a/ex_b/ex_rd : multiply offered by EX, sampled on accept
//   flush               : squash the EX instruction (only honoured in IDLE)
//   stall               : combinational freeze of IF/ID/EX
//   mul, mul_a, mul_b   : request and unsigned operands to the multiplier
//   mul_result/mul_working/mul_done : multiplier response
//   wb_en/wb_rd/wb_data : one-cycle writeback of the low product word
//   hi                  : high product word of the last completed multiply
//   err                 : sticky timeout flag
module mul_ctrl
  import mul_pkg::*;
#(
  parameter int unsigned MUL_TIMEOUT = 64
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_mul,
  input  logic              ex_signed,
  input  logic [MUL_W-1:0]  ex_a,
  input  logic [MUL_W-1:0]  ex_b,
  input  logic [RA_W-1:0]   ex_rd,
  input  logic              flush,
  output logic              stall,
  output logic              mul,
  output logic [MUL_W-1:0]  mul_a,
  output logic [MUL_W-1:0]  mul_b,
  input  logic [PROD_W-1:0] mul_result,
  input  logic              mul_working,
  input  logic              mul_done,
  output logic              wb_en,
  output logic [RA_W-1:0]   wb_rd,
  output logic [MUL_W-1:0]  wb_data,
  output logic [MUL_W-1:0]  hi,
  output logic              err
);

  localparam int unsigned     CNT_W    = $clog2(MUL_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_TIMEOUT - 1);

  mul_state_e        r_state;
  mul_state_e        w_state_nxt;
  logic              w_accept;
  logic              w_capture;
  logic              w_abort;
  logic              w_busy;

  logic              r_mul;
  logic [MUL_W-1:0]  r_a;
  logic [MUL_W-1:0]  r_b;
  logic              r_neg;
  logic [RA_W-1:0]   r_rd;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_wb_en;
  logic [RA_W-1:0]   r_wb_rd;
  logic [MUL_W-1:0]  r_wb_data;
  logic [MUL_W-1:0]  r_hi;
  logic              r_err;

  logic [MUL_W-1:0]  w_abs_a;
  logic [MUL_W-1:0]  w_abs_b;
  logic              w_neg;
  logic [PROD_W-1:0] w_prod;

  mul_sign_fix u_sign_fix (
    .i_signed (ex_signed),
    .i_a      (ex_a),
    .i_b      (ex_b),
    .o_abs_a  (w_abs_a),
    .o_abs_b  (w_abs_b),
    .o_neg    (w_neg),
    .i_neg    (r_neg),
    .i_prod   (mul_result),
    .o_prod   (w_prod)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state, control strobes and the combinational stall.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_abort     = 1'b0;
    w_busy      = 1'b0;
    stall       = 1'b0;
    case (r_state)
      IDLE: begin
        if (ex_mul && !flush) begin
          w_accept    = 1'b1;
          stall       = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE, WAIT: begin
        stall  = 1'b1;
        w_busy = 1'b1;
        // done wins over timeout on the final allowed cycle
        if (mul_done) begin
          w_capture   = 1'b1;
          w_state_nxt = WB;
        end else if (r_cnt == CNT_LAST) begin
          w_abort     = 1'b1;
          w_state_nxt = IDLE;
        end else if ((r_state == ISSUE) && mul_working) begin
          w_state_nxt = WAIT;
        end
      end
      WB:      w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand latch, timeout counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mul     <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_neg     <= 1'b0;
      r_rd      <= '0;
      r_cnt     <= '0;
      r_wb_en   <= 1'b0;
      r_wb_rd   <= '0;
      r_wb_data <= '0;
      r_hi      <= '0;
      r_err     <= 1'b0;
    end else begin
      r_wb_en <= 1'b0;
      if (w_accept) begin
        r_a   <= w_abs_a;
        r_b   <= w_abs_b;
        r_neg <= w_neg;
        r_rd  <= ex_rd;
        r_cnt <= '0;
        r_mul <= 1'b1;
      end else if (w_busy) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_capture) begin
        r_mul     <= 1'b0;
        r_wb_en   <= 1'b1;
        r_wb_rd   <= r_rd;
        r_wb_data <= w_prod[MUL_W-1:0];
        r_hi      <= w_prod[PROD_W-1:MUL_W];
      end
      if (w_abort) begin
        r_mul <= 1'b0;
        r_err <= 1'b1;
      end
    end
  end

  assign mul     = r_mul;
  assign mul_a   = r_a;
  assign mul_b   = r_b;
  assign wb_en   = r_wb_en;
  assign wb_rd   = r_wb_rd;
  assign wb_data = r_wb_data;
  assign hi      = r_hi;
  assign err     = r_err;

endmodule

// File: tb/tb_mul_ctrl.sv
// Self-checking bench for mul_ctrl: directed cases plus randomized multiplies
// against an arithmetic reference; the bench also plays the multiplier.
module tb_mul_ctrl;

  localparam int unsigned TMO = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_mul;
  logic        ex_signed;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic [4:0]  ex_rd;
  logic        flush;
  logic        stall;
  logic        mul;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [63:0] mul_result;
  logic        mul_working;
  logic        mul_done;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] hi;
  logic        err;

  int          n_chk = 0;
  int          n_bad = 0;
  logic [31:0] last_hi;
  logic        exp_err;

  always #5 clk = ~clk;

  mul_ctrl #(.MUL_TIMEOUT(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .ex_mul      (ex_mul),
    .ex_signed   (ex_signed),
    .ex_a        (ex_a),
    .ex_b        (ex_b),
    .ex_rd       (ex_rd),
    .flush       (flush),
    .stall       (stall),
    .mul         (mul),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_result  (mul_result),
    .mul_working (mul_working),
    .mul_done    (mul_done),
    .wb_en       (wb_en),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .hi          (hi),
    .err         (err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] edges [5];
    edges[0] = 32'h0000_0000;
    edges[1] = 32'h0000_0001;
    edges[2] = 32'h8000_0000;
    edges[3] = 32'hFFFF_FFFF;
    edges[4] = 32'h7FFF_FFFF;
    if ($urandom_range(3) == 0) return edges[$urandom_range(4)];
    return $urandom;
  endfunction

  // One full multiply: accept, lat idle cycles, done, writeback, one IDLE cycle.
  task automatic do_mul(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int lat, input logic wk,
                        input logic fl_mid);
    logic [31:0] ea;
    logic [31:0] eb;
    logic [63:0] ep;
    ea = (s && a[31]) ? 32'(-$signed(a)) : a;
    eb = (s && b[31]) ? 32'(-$signed(b)) : b;
    ep = s ? 64'(longint'($signed(a)) * longint'($signed(b))) : (64'(a) * 64'(b));

    ex_mul = 1'b1; ex_signed = s; ex_a = a; ex_b = b; ex_rd = rd;
    #1 chk("stall_accept", 64'(stall), 64'd1);
    tick();
    ex_mul = 1'b0; ex_signed = 1'($urandom); ex_a = $urandom; ex_b = $urandom;
    ex_rd = 5'($urandom);
    chk("mul_rise", 64'(mul), 64'd1);
    chk("mul_a", 64'(mul_a), 64'(ea));
    chk("mul_b", 64'(mul_b), 64'(eb));
    for (int i = 0; i < lat; i++) begin
      chk("stall_busy", 64'(stall), 64'd1);
      chk("wb_quiet", 64'(wb_en), 64'd0);
      mul_working = wk;
      if (fl_mid) flush = 1'b1;
      tick();
    end
    chk("stall_done", 64'(stall), 64'd1);
    chk("mul_held", 64'(mul), 64'd1);
    mul_done   = 1'b1;
    mul_result = 64'(mul_a) * 64'(mul_b);
    tick();
    mul_done = 1'b0; mul_working = 1'b0; flush = 1'b0;
    mul_result = {$urandom, $urandom};
    chk("wb_en", 64'(wb_en), 64'd1);
    chk("wb_rd", 64'(wb_rd), 64'(rd));
    chk("wb_data", 64'(wb_data), 64'(ep[31:0]));
    chk("hi", 64'(hi), 64'(ep[63:32]));
    chk("stall_wb", 64'(stall), 64'd0);
    chk("mul_wb", 64'(mul), 64'd0);
    chk("err", 64'(err), 64'(exp_err));
    last_hi = ep[63:32];
    tick();
    chk("wb_once", 64'(wb_en), 64'd0);
    chk("hi_hold", 64'(hi), 64'(last_hi));
    chk("stall_idle", 64'(stall), 64'd0);
  endtask

  initial begin
    int   n;
    logic saw_wb;
    logic early_err;

    reset = 1'b1; ex_mul = 1'b0; ex_signed = 1'b0; ex_a = '0; ex_b = '0; ex_rd = '0;
    flush = 1'b0; mul_result = '0; mul_working = 1'b0; mul_done = 1'b0;
    last_hi = '0; exp_err = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_mul", 64'(mul), 64'd0);
    chk("rst_wb_en", 64'(wb_en), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_wb_data", 64'(wb_data), 64'd0);

    // directed arithmetic cases
    do_mul(1'b0, 32'd2, 32'd2, 5'd7, 2, 1'b1, 1'b0);
    do_mul(1'b1, 32'hFFFF_FFFD, 32'd5, 5'd3, 1, 1'b1, 1'b0);
    do_mul(1'b1, 32'h8000_0000, 32'h8000_0000, 5'd9, 3, 1'b1, 1'b0);
    do_mul(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 0, 1'b0, 1'b0);
    do_mul(1'b1, 32'd7, 32'hFFFF_FFFF, 5'd1, 0, 1'b0, 1'b0);
    // flush in WAIT must not stop the writeback
    do_mul(1'b0, 32'd11, 32'd13, 5'd4, 3, 1'b1, 1'b1);

    // flush in IDLE: nothing accepted
    ex_mul = 1'b1; flush = 1'b1; ex_a = 32'd5; ex_b = 32'd5; ex_rd = 5'd2;
    #1 chk("flush_stall", 64'(stall), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("flush_mul", 64'(mul), 64'd0);
      chk("flush_wb", 64'(wb_en), 64'd0);
      chk("flush_stall_hold", 64'(stall), 64'd0);
    end
    ex_mul = 1'b0; flush = 1'b0;

    // reset while waiting on the multiplier
    ex_mul = 1'b1; ex_signed = 1'b0; ex_a = 32'd9; ex_b = 32'd9; ex_rd = 5'd3;
    tick();
    ex_mul = 1'b0; mul_working = 1'b1;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; mul_working = 1'b0;
    chk("mrst_stall", 64'(stall), 64'd0);
    chk("mrst_mul", 64'(mul), 64'd0);
    chk("mrst_wb_en", 64'(wb_en), 64'd0);
    chk("mrst_hi", 64'(hi), 64'd0);
    chk("mrst_wb_data", 64'(wb_data), 64'd0);
    chk("mrst_wb_rd", 64'(wb_rd), 64'd0);
    chk("mrst_mul_a", 64'(mul_a), 64'd0);
    chk("mrst_mul_b", 64'(mul_b), 64'd0);
    chk("mrst_err", 64'(err), 64'd0);
    saw_wb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (wb_en || mul) saw_wb = 1'b1;
    end
    chk("mrst_quiet", 64'(saw_wb), 64'd0);
    last_hi = '0;
    do_mul(1'b0, 32'd6, 32'd7, 5'd12, 2, 1'b1, 1'b0);

    // timeout: the multiplier never finishes
    ex_mul = 1'b1; ex_signed = 1'b1; ex_a = 32'd3; ex_b = 32'd4; ex_rd = 5'd5;
    tick();
    ex_mul = 1'b0; mul_working = 1'b1;
    n = 0; saw_wb = 1'b0; early_err = 1'b0;
    while (stall && n < 100) begin
      n++;
      if (wb_en) saw_wb = 1'b1;
      if (err) early_err = 1'b1;
      tick();
    end
    mul_working = 1'b0;
    chk("tmo_cycles", 64'(n), 64'(TMO));
    chk("tmo_err", 64'(err), 64'd1);
    chk("tmo_early_err", 64'(early_err), 64'd0);
    chk("tmo_no_wb", 64'(saw_wb | wb_en), 64'd0);
    chk("tmo_mul", 64'(mul), 64'd0);
    chk("tmo_hi_hold", 64'(hi), 64'(last_hi));
    exp_err = 1'b1;
    do_mul(1'b1, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 5'd6, 1, 1'b1, 1'b0);

    // randomized multiplies, back to back
    for (int k = 0; k < 40; k++) begin
      do_mul(1'($urandom), pick(), pick(), 5'($urandom), int'($urandom_range(4)),
             1'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/mul_ctrl.md
# mul_ctrl

Multiply issue/writeback controller between the EX stage and the multi-cycle `multiplier`. It latches a multiply from EX, stalls the front of the pipeline, and drives the `multiplier` handshake (`mul`/`working`/`done`). It applies signed correction around the unsigned core, then delivers the low word to writeback and the high word to the `hi` register.

## Interface
- `MUL_TIMEOUT`, 64: max cycles from issue to `mul_done` before abort.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `ex_mul` in 1: EX holds a valid MULT/MULTU.
- `ex_signed` in 1: 1 = MULT (two's complement), 0 = MULTU.
- `ex_a`, `ex_b` in [0:31]: operands, bit 0 = MSB.
- `ex_rd` in [0:4]: destination register.
- `flush` in 1: squash the EX instruction.
- `stall` out 1: freeze IF/ID/EX.
- `mul` out 1: request to `multiplier`.
- `mul_a`, `mul_b` out [0:31]: unsigned operands to `multiplier`.
- `mul_result` in [0:63]: unsigned product from `multiplier`.
- `mul_working` in 1: `multiplier` busy.
- `mul_done` in 1: `multiplier` finished.
- `wb_en` out 1: one-cycle register write strobe.
- `wb_rd` out [0:4]: write destination.
- `wb_data` out [0:31]: low product word.
- `hi` out [0:31]: high product word, holds until the next completed multiply.
- `err` out 1: sticky timeout flag.

## Operation
- States: IDLE, ISSUE, WAIT, WB.
- **IDLE**
  - `ex_mul & !flush`: latch |a|, |b|, `neg = ex_signed & (a[0] ^ b[0])`, and `ex_rd`; go to ISSUE.
  - `flush` has priority; no acceptance.
- **ISSUE**
  - `mul=1`. `mul_working` → WAIT. `mul_done` (even without prior `working`) → capture and go to WB.
- **WAIT**
  - `mul=1`. `mul_done` → capture and go to WB.
- **Abort**
  - The cycle counter starts at 0 on entry to ISSUE and increments in ISSUE and WAIT.
  - Count reaching `MUL_TIMEOUT` without `done` → `err<=1`, go to IDLE, no writeback.
- **WB**
  - `wb_en=1`, `wb_rd=rd`, `wb_data=p[32:63]`, `hi<=p[0:31]`; go to IDLE.
- **Capture**
  - `p = neg ? (~mul_result + 1) : mul_result`, 64-bit, modulo 2^64.
- **Absolute value**
  - If signed and MSB set, |x| = ~x+1 in 32 bits.
  - 0x80000000 maps to 0x80000000, which is correct as unsigned.
- `flush` is ignored outside IDLE; an issued multiply always completes.
- `ex_*` inputs are sampled only on the IDLE acceptance edge.

## Timing
- **`stall`** is combinational:
  - 1 in IDLE when `ex_mul & !flush`.
  - 1 in ISSUE and WAIT.
  - 0 in WB.
  - The pipeline advances on the WB edge, so the same instruction is never re-accepted.
- **`mul`** is registered: high from ISSUE entry until the capture edge, low in WB and IDLE.
- **Latency:** accept edge T, ISSUE at T+1. If `done` is seen at cycle D, WB is at D+1 and `wb_en` is high for exactly one cycle.
- **Back-to-back:** a second multiply may be accepted in the IDLE cycle directly after WB.
- **Reset** (any state):
  - Next cycle: state=IDLE.
  - `mul`, `wb_en`, `err`, `stall` = 0.
  - `hi`, `wb_data`, `mul_a`, `mul_b` = 0; `wb_rd`=0.
  - The in-flight multiply is discarded. `multiplier` shares `reset`.
- **`err`** clears only on reset and does not block further multiplies.

## Structure
- Package `mul_pkg`:
  - state enum (IDLE, ISSUE, WAIT, WB).
  - `MUL_W=32`, `PROD_W=64`, `RA_W=5`.
- Sub-module `mul_sign_fix`: combinational abs/negate helpers, used for the operands and the 64-bit product.
- Counter width: `$clog2(MUL_TIMEOUT+1)`.

## Test plan
- **Unsigned:** MULTU 2×2, rd=7, with the real `multiplier`. Expect `stall` high from accept to WB, one `wb_en`, `wb_rd`=7, `wb_data`=4, `hi`=0.
- **Signed:** MULT −3×5. Expect `mul_a`=3, `mul_b`=5, `wb_data`=0xFFFFFFF1, `hi`=0xFFFFFFFF.
- **Edge operands:**
  - MULT 0x80000000×0x80000000 → `hi`=0x40000000, `wb_data`=0.
  - MULTU 0xFFFFFFFF×0xFFFFFFFF → `hi`=0xFFFFFFFE, `wb_data`=1.
- **Flush:** `flush`=1 with `ex_mul`=1 in IDLE → `stall`=0, `mul` never rises, no `wb_en`. `flush` asserted during WAIT → writeback still occurs.
- **Reset mid-WAIT:** reset during WAIT → next cycle IDLE, all outputs 0, no `wb_en`. The following MULTU 6×7 yields 42.
- **Timeout:** stub that never asserts `done` → `err`=1 after 64 cycles in ISSUE/WAIT, return to IDLE, `stall`=0, no `wb_en`. A subsequent multiply completes with `err` still 1.
